multi_sel_collect: RTL

- Downstream consumer of the x1/x3/x7/x9 multiplier sequencer.
- Samples the sequencer's 11-bit result word and its grant strobe every cycle, and assembles each 4-word burst into one 44-bit frame.
- Buffers frames in a small FIFO and presents them on a valid/ready interface to the next stage.

---
 rtl/multi_pkg.sv | 10 +
 rtl/multi_frame_fifo.sv | 46 ++++
 rtl/multi_sel_collect.sv | 108 ++++++++++
 3 files changed

// File: rtl/multi_pkg.sv
// multi_pkg: shared widths, multiplier constants and FSM states for the x1/x3/x7/x9 frame collector
package multi_pkg;
  localparam int WORD_W = 11;
  localparam int FRAME_W = 4 * WORD_W;
  localparam int MUL1 = 1;
  localparam int MUL3 = 3;
  localparam int MUL7 = 7;
  localparam int MUL9 = 9;
  typedef enum logic [1:0] {IDLE, S1, S2, S3} state_e;
endpackage

// File: rtl/multi_frame_fifo.sv
// multi_frame_fifo: show-ahead FRAME_W x DEPTH FIFO, async active-low reset
// ports: clk, rst (active-low), push/push_data, pop, pop_data (head entry), full, empty, fill
module multi_frame_fifo #(
  parameter int FRAME_W = 44,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [FRAME_W-1:0]       push_data,
  input  logic                     pop,
  output logic [FRAME_W-1:0]       pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [FRAME_W-1:0] mem_q [DEPTH];
  logic [FRAME_W-1:0] mem_d [DEPTH];
  logic do_push, do_pop;
  assign fill = wr_q - rd_q;
  assign empty = wr_q == rd_q;
  assign full = fill == (AW+1)'(DEPTH);
  assign pop_data = mem_q[rd_q[AW-1:0]];
  assign do_pop = pop & ~empty;
  // a pop frees the slot in the same edge, so a full FIFO still accepts
  assign do_push = push & (~full | do_pop);
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q[AW-1:0]] = push_data;
    wr_d = wr_q + (AW+1)'(do_push);
    rd_d = rd_q + (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/multi_sel_collect.sv
// multi_sel_collect: assembles x1/x3/x7/x9 result bursts into 44-bit frames and queues them
// ports: clk, rst (async active-low), in_grant/in_data from the sequencer,
//        frame_valid/frame_ready/frame_data to the next stage, fill, sticky overflow/sync_err/chk_err
// optional: MULT_CHECK_EN enables the per-frame multiple check driving chk_err
module multi_sel_collect
  import multi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WORD_W = multi_pkg::WORD_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_grant,
  input  logic [WORD_W-1:0]       in_data,
  input  logic                    frame_ready,
  output logic                    frame_valid,
  output logic [4*WORD_W-1:0]     frame_data,
  output logic [$clog2(DEPTH):0]  fill,
  output logic                    overflow,
  output logic                    sync_err,
  output logic                    chk_err
);
  localparam int FW = 4 * WORD_W;
  state_e state_q, state_d;
  logic [WORD_W-1:0] slot0_q, slot0_d, slot1_q, slot1_d, slot2_q, slot2_d;
  logic seen_q, seen_d, sync_q, sync_d, ovf_q, ovf_d;
  logic push, pop, full, empty;
  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    slot2_d = slot2_q;
    seen_d = seen_q | in_grant;
    sync_d = sync_q;
    push = 1'b0;
    if (in_grant) begin
      // grant always restarts a frame; mid-frame it discards the partial one
      sync_d = sync_q | (state_q != IDLE);
      slot0_d = in_data;
      state_d = S1;
    end else begin
      case (state_q)
        IDLE: sync_d = sync_q | (seen_q & (in_data != '0));
        S1: begin
          slot1_d = in_data;
          state_d = S2;
        end
        S2: begin
          slot2_d = in_data;
          state_d = S3;
        end
        S3: begin
          push = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end
  assign frame_valid = ~empty;
  assign pop = frame_valid & frame_ready;
  assign ovf_d = ovf_q | (push & full & ~pop);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      slot0_q <= '0;
      slot1_q <= '0;
      slot2_q <= '0;
      seen_q <= 1'b0;
      sync_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      slot2_q <= slot2_d;
      seen_q <= seen_d;
      sync_q <= sync_d;
      ovf_q <= ovf_d;
    end
  end
  assign overflow = ovf_q;
  assign sync_err = sync_q;
`ifdef MULT_CHECK_EN
  logic chk_q, chk_d;
  always_comb
    chk_d = chk_q | (push & ((slot1_q != WORD_W'(slot0_q * MUL3)) |
                             (slot2_q != WORD_W'(slot0_q * MUL7)) |
                             (in_data != WORD_W'(slot0_q * MUL9))));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chk_q <= 1'b0;
    else chk_q <= chk_d;
  end
  assign chk_err = chk_q;
`else
  assign chk_err = 1'b0;
`endif
  multi_frame_fifo #(.FRAME_W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_data({in_data, slot2_q, slot1_q, slot0_q}),
    .pop(pop),
    .pop_data(frame_data),
    .full(full),
    .empty(empty),
    .fill(fill)
  );
endmodule
